// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: command codes, FSM states and
// the operand-requirement classifier for alu_seq.
package alu_seq_pkg;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_ADDC = 4'd2;
  localparam logic [3:0] A_SUBC = 4'd3;
  localparam logic [3:0] A_INCA = 4'd4;
  localparam logic [3:0] A_DECA = 4'd5;
  localparam logic [3:0] A_INCB = 4'd6;
  localparam logic [3:0] A_DECB = 4'd7;
  localparam logic [3:0] A_CMP  = 4'd8;
  localparam logic [3:0] A_MULI = 4'd9;
  localparam logic [3:0] A_MULS = 4'd10;

  localparam logic [3:0] L_AND  = 4'd0;
  localparam logic [3:0] L_NAND = 4'd1;
  localparam logic [3:0] L_OR   = 4'd2;
  localparam logic [3:0] L_NOR  = 4'd3;
  localparam logic [3:0] L_XOR  = 4'd4;
  localparam logic [3:0] L_XNOR = 4'd5;
  localparam logic [3:0] L_NOTA = 4'd6;
  localparam logic [3:0] L_NOTB = 4'd7;
  localparam logic [3:0] L_SHRA = 4'd8;
  localparam logic [3:0] L_SHLA = 4'd9;
  localparam logic [3:0] L_SHRB = 4'd10;
  localparam logic [3:0] L_SHLB = 4'd11;
  localparam logic [3:0] L_ROL  = 4'd12;
  localparam logic [3:0] L_ROR  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_EXEC2 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CL_TWO = 3'd0,
    CL_A   = 3'd1,
    CL_B   = 3'd2,
    CL_MUL = 3'd3,
    CL_BAD = 3'd4
  } op_class_t;

  function automatic op_class_t cmd_class(
    input logic       mode,
    input logic [3:0] cmd
  );
    op_class_t c;
    c = CL_BAD;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADDC,
        A_SUBC, A_CMP:          c = CL_TWO;
        A_INCA, A_DECA:         c = CL_A;
        A_INCB, A_DECB:         c = CL_B;
        A_MULI, A_MULS:         c = CL_MUL;
        default:                c = CL_BAD;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR,
        L_NOR, L_XOR, L_XNOR,
        L_ROL, L_ROR:           c = CL_TWO;
        L_NOTA, L_SHRA, L_SHLA: c = CL_A;
        L_NOTB, L_SHRB, L_SHLB: c = CL_B;
        default:                c = CL_BAD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_core: combinational compute of result and
// flags from the latched command and operands.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           mode_i,
  input  logic           cin_i,
  input  logic [3:0]     cmd_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] res_o,
  output logic           cout_o,
  output logic           of_o,
  output logic           g_o,
  output logic           l_o,
  output logic           e_o,
  output logic           err_o
);

  localparam int SW = $clog2(W);
  localparam logic [2*W-1:0] ONE =
    {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] M1 =
    {{(W-1){1'b0}}, {(W+1){1'b1}}};

  logic [2*W-1:0] ax, bx, cx;
  logic [2*W-1:0] add_r, sub_r;
  logic [W-1:0]   a_sh, hi, lw;
  logic [SW-1:0]  sh;
  logic [2*W-1:0] dbl;

  assign ax    = {{W{1'b0}}, a_i};
  assign bx    = {{W{1'b0}}, b_i};
  assign cx    = {{(2*W-1){1'b0}}, cin_i};
  assign add_r = ax + bx
               + ((cmd_i == A_ADDC) ? cx : '0);
  assign sub_r = ax - bx
               - ((cmd_i == A_SUBC) ? cx : '0);
  assign a_sh  = a_i << 1;
  assign sh    = b_i[SW-1:0];
  assign hi    = b_i >> SW;

  // decode the command into result and flags
  always_comb begin
    res_o  = '0;
    cout_o = 1'b0;
    of_o   = 1'b0;
    g_o    = 1'b0;
    l_o    = 1'b0;
    e_o    = 1'b0;
    err_o  = 1'b0;
    lw     = '0;
    dbl    = '0;
    if (mode_i) begin
      case (cmd_i)
        A_ADD, A_ADDC: begin
          res_o  = add_r;
          cout_o = add_r[W];
        end
        A_SUB, A_SUBC: begin
          res_o = sub_r;
          of_o  = sub_r[2*W-1];
        end
        A_INCA: res_o = ax + ONE;
        A_DECA: res_o = (ax - ONE) & M1;
        A_INCB: res_o = bx + ONE;
        A_DECB: res_o = (bx - ONE) & M1;
        A_CMP: begin
          e_o = (a_i == b_i);
          g_o = (a_i >  b_i);
          l_o = (a_i <  b_i);
        end
        A_MULI: res_o = (ax + ONE) * (bx + ONE);
        A_MULS: res_o = {{W{1'b0}}, a_sh} * bx;
        default: err_o = 1'b1;
      endcase
    end else begin
      case (cmd_i)
        L_AND:  lw = a_i & b_i;
        L_NAND: lw = ~(a_i & b_i);
        L_OR:   lw = a_i | b_i;
        L_NOR:  lw = ~(a_i | b_i);
        L_XOR:  lw = a_i ^ b_i;
        L_XNOR: lw = ~(a_i ^ b_i);
        L_NOTA: lw = ~a_i;
        L_NOTB: lw = ~b_i;
        L_SHRA: lw = a_i >> 1;
        L_SHLA: lw = a_i << 1;
        L_SHRB: lw = b_i >> 1;
        L_SHLB: lw = b_i << 1;
        L_ROL: begin
          dbl = {a_i, a_i} << sh;
          lw  = dbl[2*W-1:W];
          if (|hi) begin
            lw    = '0;
            err_o = 1'b1;
          end
        end
        L_ROR: begin
          dbl = {a_i, a_i} >> sh;
          lw  = dbl[W-1:0];
          if (|hi) begin
            lw    = '0;
            err_o = 1'b1;
          end
        end
        default: err_o = 1'b1;
      endcase
      res_o = {{W{1'b0}}, lw};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with operand collection,
// timeout and a two-stage multiply path.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           CE,
  input  logic           MODE,
  input  logic           Cin,
  input  logic [1:0]     IN_valid,
  input  logic [3:0]     CMD,
  input  logic [W-1:0]   OPA,
  input  logic [W-1:0]   OPB,
  output logic           READY,
  output logic           OUT_valid,
  output logic [2*W-1:0] RES,
  output logic           COUT,
  output logic           OF,
  output logic           G,
  output logic           L,
  output logic           E,
  output logic           ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic           cin_q, cin_d;
  logic [3:0]     cmd_q, cmd_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           need_b_q, need_b_d;
  logic           miss_q, miss_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] res_q, res_d;
  logic           cout_q, cout_d, of_q, of_d;
  logic           g_q, g_d, l_q, l_d, e_q, e_d;
  logic           err_q, err_d, ov_q, ov_d;

  op_class_t      cls_in, cls_q;
  logic [2*W-1:0] c_res;
  logic           c_cout, c_of, c_g, c_l;
  logic           c_e, c_err;

  alu_core #(.W(W)) u_core (
    .mode_i (mode_q),
    .cin_i  (cin_q),
    .cmd_i  (cmd_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .res_o  (c_res),
    .cout_o (c_cout),
    .of_o   (c_of),
    .g_o    (c_g),
    .l_o    (c_l),
    .e_o    (c_e),
    .err_o  (c_err)
  );

  assign cls_in    = cmd_class(MODE, CMD);
  assign cls_q     = cmd_class(mode_q, cmd_q);
  assign READY     = (state_q == S_IDLE);
  assign OUT_valid = ov_q & CE;
  assign RES       = res_q;
  assign COUT      = cout_q;
  assign OF        = of_q;
  assign G         = g_q;
  assign L         = l_q;
  assign E         = e_q;
  assign ERR       = err_q;

  // next-state: operand collection, timeout, execute
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    need_b_d = need_b_q;
    miss_d   = miss_q;
    prod_d   = prod_q;
    res_d    = res_q;
    cout_d   = cout_q;
    of_d     = of_q;
    g_d      = g_q;
    l_d      = l_q;
    e_d      = e_q;
    err_d    = err_q;
    ov_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (IN_valid != 2'b00) begin
          mode_d  = MODE;
          cin_d   = Cin;
          cmd_d   = CMD;
          cnt_d   = '0;
          miss_d  = 1'b0;
          state_d = S_EXEC;
          if (IN_valid[0]) a_d = OPA;
          if (IN_valid[1]) b_d = OPB;
          if ((cls_in == CL_TWO ||
               cls_in == CL_MUL) &&
              IN_valid != 2'b11) begin
            state_d  = S_WAIT;
            need_b_d = ~IN_valid[1];
          end
          if (cls_in == CL_A && !IN_valid[0])
            miss_d = 1'b1;
          if (cls_in == CL_B && !IN_valid[1])
            miss_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (need_b_q ? IN_valid[1]
                     : IN_valid[0]) begin
          if (need_b_q) b_d = OPB;
          else          a_d = OPA;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          res_d   = '0;
          cout_d  = 1'b0;
          of_d    = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (cls_q == CL_MUL) begin
          prod_d  = c_res;
          state_d = S_EXEC2;
        end else begin
          res_d   = miss_q ? '0 : c_res;
          cout_d  = c_cout & ~miss_q;
          of_d    = c_of   & ~miss_q;
          g_d     = c_g    & ~miss_q;
          l_d     = c_l    & ~miss_q;
          e_d     = c_e    & ~miss_q;
          err_d   = c_err  |  miss_q;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        res_d   = prod_q;
        cout_d  = 1'b0;
        of_d    = 1'b0;
        g_d     = 1'b0;
        l_d     = 1'b0;
        e_d     = 1'b0;
        err_d   = 1'b0;
        ov_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // state update; reset wins, CE=0 freezes all
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      need_b_q <= 1'b0;
      miss_q   <= 1'b0;
      prod_q   <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
      g_q      <= 1'b0;
      l_q      <= 1'b0;
      e_q      <= 1'b0;
      err_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else if (CE) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      need_b_q <= need_b_d;
      miss_q   <= miss_d;
      prod_q   <= prod_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      of_q     <= of_d;
      g_q      <= g_d;
      l_q      <= l_d;
      e_q      <= e_d;
      err_q    <= err_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for
// alu_seq with W=8, TIMEOUT=16.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, CE, MODE, Cin;
  logic [1:0]  IN_valid;
  logic [3:0]  CMD;
  logic [7:0]  OPA, OPB;
  logic        READY, OUT_valid;
  logic [15:0] RES;
  logic        COUT, OF, G, L, E, ERR;

  int checks = 0;
  int errors = 0;
  int early;

  alu_seq #(.W(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .CE        (CE),
    .MODE      (MODE),
    .Cin       (Cin),
    .IN_valid  (IN_valid),
    .CMD       (CMD),
    .OPA       (OPA),
    .OPB       (OPB),
    .READY     (READY),
    .OUT_valid (OUT_valid),
    .RES       (RES),
    .COUT      (COUT),
    .OF        (OF),
    .G         (G),
    .L         (L),
    .E         (E),
    .ERR       (ERR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string       tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic issue(input logic       m,
                       input logic [3:0] c,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [1:0] v);
    MODE = m; CMD = c; OPA = a; OPB = b;
    IN_valid = v;
  endtask

  initial begin
    rst = 1'b1; CE = 1'b1; Cin = 1'b0;
    issue(1'b0, 4'd0, 8'd0, 8'd0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    chk("rst_res", RES, 0);
    chk("rst_ov", OUT_valid, 0);
    chk("rst_rdy", READY, 1);
    chk("rst_err", ERR, 0);

    // ADD 0xFF + 0x01
    issue(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11);
    tick();
    IN_valid = 2'b00;
    chk("add_rdy_lo", READY, 0);
    chk("add_ov_lo", OUT_valid, 0);
    tick();
    chk("add_ov", OUT_valid, 1);
    chk("add_res", RES, 16'h0100);
    chk("add_cout", COUT, 1);
    chk("add_err", ERR, 0);
    chk("add_rdy", READY, 1);
    tick();
    chk("add_pulse", OUT_valid, 0);
    chk("add_hold", RES, 16'h0100);

    // MUL_INC (3+1)*(4+1), junk while busy
    issue(1'b1, 4'd9, 8'd3, 8'd4, 2'b11);
    tick();
    issue(1'b1, 4'd0, 8'h11, 8'h22, 2'b11);
    chk("mul_rdy1", READY, 0);
    chk("mul_ov1", OUT_valid, 0);
    tick();
    chk("mul_rdy2", READY, 0);
    chk("mul_ov2", OUT_valid, 0);
    tick();
    IN_valid = 2'b00;
    chk("mul_ov", OUT_valid, 1);
    chk("mul_res", RES, 16'd20);
    chk("mul_cout", COUT, 0);
    chk("mul_rdy", READY, 1);
    tick();
    chk("mul_trace_ov", OUT_valid, 0);
    chk("mul_trace_res", RES, 16'd20);

    // ADD with operands in separate cycles
    issue(1'b1, 4'd0, 8'd5, 8'd0, 2'b01);
    tick();
    issue(1'b1, 4'd0, 8'h99, 8'd0, 2'b00);
    chk("wait_rdy", READY, 0);
    tick(); tick();
    issue(1'b1, 4'd5, 8'h99, 8'd7, 2'b10);
    tick();
    IN_valid = 2'b00;
    chk("wait_ov_lo", OUT_valid, 0);
    tick();
    chk("wait_ov", OUT_valid, 1);
    chk("wait_res", RES, 16'd12);
    chk("wait_err", ERR, 0);

    // SUB with no OPB: timeout after 16 cycles
    issue(1'b1, 4'd1, 8'd9, 8'd0, 2'b01);
    tick();
    IN_valid = 2'b00;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (OUT_valid) early++;
    end
    chk("to_early", early, 0);
    tick();
    chk("to_ov", OUT_valid, 1);
    chk("to_err", ERR, 1);
    chk("to_res", RES, 0);
    chk("to_rdy", READY, 1);
    tick();
    chk("to_pulse", OUT_valid, 0);

    // ROL 0x81 by 1, then illegal amount
    issue(1'b0, 4'd12, 8'h81, 8'h01, 2'b11);
    tick();
    IN_valid = 2'b00;
    tick();
    chk("rol_res", RES, 16'h0003);
    chk("rol_err", ERR, 0);
    issue(1'b0, 4'd12, 8'h81, 8'h11, 2'b11);
    tick();
    IN_valid = 2'b00;
    tick();
    chk("rolx_ov", OUT_valid, 1);
    chk("rolx_res", RES, 0);
    chk("rolx_err", ERR, 1);

    // SUB 3-5 borrows
    issue(1'b1, 4'd1, 8'd3, 8'd5, 2'b11);
    tick();
    IN_valid = 2'b00;
    tick();
    chk("sub_res", RES, 16'hFFFE);
    chk("sub_of", OF, 1);
    chk("sub_err", ERR, 0);

    // INC_A with only OPB valid
    issue(1'b1, 4'd4, 8'd1, 8'd9, 2'b10);
    tick();
    IN_valid = 2'b00;
    tick();
    chk("inca_ov", OUT_valid, 1);
    chk("inca_err", ERR, 1);
    chk("inca_res", RES, 0);

    // CE low before EXEC completes
    issue(1'b1, 4'd0, 8'd2, 8'd3, 2'b11);
    tick();
    IN_valid = 2'b00;
    CE = 1'b0;
    tick(); tick();
    chk("ce_ov", OUT_valid, 0);
    chk("ce_rdy", READY, 0);
    chk("ce_res", RES, 0);
    CE = 1'b1;
    tick();
    chk("ce_ov2", OUT_valid, 1);
    chk("ce_res2", RES, 16'd5);

    // CE low while pulse pending
    issue(1'b1, 4'd0, 8'd4, 8'd4, 2'b11);
    tick();
    IN_valid = 2'b00;
    tick();
    CE = 1'b0;
    #1;
    chk("cep_ov", OUT_valid, 0);
    chk("cep_res", RES, 16'd8);
    tick();
    chk("cep_ov2", OUT_valid, 0);
    CE = 1'b1;
    #1;
    chk("cep_ov3", OUT_valid, 1);
    tick();
    chk("cep_ov4", OUT_valid, 0);

    // CMP equal
    issue(1'b1, 4'd8, 8'h40, 8'h40, 2'b11);
    tick();
    IN_valid = 2'b00;
    tick();
    chk("cmp_e", E, 1);
    chk("cmp_g", G, 0);
    chk("cmp_l", L, 0);
    chk("cmp_res", RES, 0);

    // reset during WAIT
    issue(1'b1, 4'd0, 8'd1, 8'd0, 2'b01);
    tick();
    IN_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_e", E, 0);
    chk("rw_res", RES, 0);
    chk("rw_rdy", READY, 1);
    chk("rw_ov", OUT_valid, 0);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (OUT_valid) early++;
    end
    chk("rw_quiet", early, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the current 8-bit ALU (`aluDesign`) in the datapath. It widens operands to W bits and adds an operand-collection FSM, so OPA and OPB may arrive in different cycles, bounded by a timeout. It adds two-cycle multiply commands with a READY/OUT_valid handshake. It sits between the stimulus or issue logic and the result sink, with the same command and flag semantics as the current ALU.

## Interface
- W, default 8: operand width; results are 2W bits.
- TIMEOUT, default 16: maximum cycles spent waiting for a missing operand.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- CE  in  1  clock enable; 0 freezes all state.
- MODE  in  1  1 = arithmetic, 0 = logical.
- Cin  in  1  carry in, used by ADD_CIN and SUB_CIN.
- IN_valid  in  2  bit0 = OPA valid, bit1 = OPB valid.
- CMD  in  4  command code.
- OPA, OPB  in  W  operands, unsigned.
- READY  out  1  block can accept a command this cycle.
- OUT_valid  out  1  one-cycle pulse; RES and flags are valid.
- RES  out  2W  result.
- COUT, OF, G, L, E, ERR  out  1 each  flags.

## Operation
- **Arithmetic commands (MODE=1):**
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP: sets E/G/L; RES=0.
  - 9 MUL_INC: (A+1)*(B+1).
  - 10 MUL_SHL: ((A<<1) mod 2^W)*B.
  - 11–15: ERR.
- **Logical commands (MODE=0):**
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by OPB[$clog2(W)-1:0]. ERR if any higher bit of OPB is set; RES=0 in that case.
  - 14–15: ERR.
  - Logical results are zero-extended W-bit values.
- **Arithmetic width rules:**
  - ADD/ADD_CIN: RES[W:0] = A+B(+Cin); COUT = RES[W].
  - SUB/SUB_CIN: RES = A-B(-Cin), truncated to 2W bits; OF = 1 on borrow.
  - INC/DEC: W+1-bit result.
  - MUL: full 2W-bit result.
- **Operand requirement:** two-operand commands need both bits of IN_valid. Single-operand commands need only their own bit. If a command is accepted with its required bits already present, it executes directly.
- **FSM states:**
  - IDLE (READY=1): samples CMD/MODE/Cin and any valid operands when IN_valid≠00.
    - Required bits all present → EXEC.
    - Two-operand command with one bit present → WAIT, latching the present operand.
    - IN_valid=00 → stay in IDLE, no effect.
  - WAIT (READY=0): counts cycles.
    - Missing operand arrives → EXEC; the other IN_valid bit and CMD are ignored.
    - Counter reaches TIMEOUT → ERR=1, RES=0, OUT_valid, back to IDLE.
  - EXEC: registers the result and pulses OUT_valid, then returns to IDLE.
    - Multiply passes through EXEC2 (one extra stage); READY=0 throughout.
- **Flags:**
  - E/G/L are updated only by CMP and are 0 otherwise.
  - ERR also covers invalid commands and a missing single operand (e.g. INC_A with IN_valid=10).
- **Output hold:** all outputs except OUT_valid hold their last values until the next result.
- **CE=0:** state, counters and outputs freeze; OUT_valid=0. Any pending OUT_valid pulse is delivered on the first CE=1 cycle.

## Timing
- **Reset:**
  - rst sampled high → next edge: RES=0, all flags 0, OUT_valid=0, READY=1, FSM=IDLE, timeout counter=0.
  - Reset mid-WAIT or mid-multiply abandons the operation with no OUT_valid.
  - rst has priority over CE.
- **Latency:** command accepted at edge N (inputs already present) → OUT_valid high in cycle after edge N+1. Multiply → after edge N+2.
- **WAIT timing:** operand arrives at edge M → result after edge M+1. Timeout: OUT_valid follows the edge at which the counter reaches TIMEOUT, which is TIMEOUT cycles after entry.
- **Throughput:** back-to-back non-multiply commands are accepted every 2 cycles (accept, EXEC). Inputs presented while READY=0 are ignored; the issuer must hold them until READY.

## Structure
- Package alu_seq_pkg holds:
  - arithmetic and logical command code constants;
  - FSM state enum (IDLE, WAIT, EXEC, EXEC2);
  - a function classifying each command as two-operand, A-only, B-only, multiply, or invalid.
- Sub-module alu_core: purely combinational W-parametrised compute of RES and flags from latched CMD/MODE/Cin/A/B. alu_seq holds the FSM, operand latches, timeout counter and multiply stage.

## Test plan
- W=8, MODE=1, CMD=0, A=0xFF, B=0x01, IN_valid=11 → OUT_valid 2 edges later, RES=0x0100, COUT=1, ERR=0.
- MODE=1, CMD=9, A=3, B=4, IN_valid=11 → READY low for 2 cycles, RES=20 after edge N+2; ignored mid-operation command leaves no trace.
- MODE=1, CMD=0, A=5 with IN_valid=01; OPB=7 with IN_valid=10 three cycles later → RES=12, OUT_valid one cycle after OPB accept.
- CMD=1, IN_valid=01 and no OPB for 16 cycles → ERR=1, RES=0, OUT_valid once, READY returns high.
- MODE=0, CMD=12, A=0x81, B=0x01 → RES=0x03. Same with B=0x11 → ERR=1, RES=0.
- MODE=1, CMD=8, A=B=0x40 → E=1, G=L=0. Then rst asserted during WAIT → all outputs 0, READY=1, no OUT_valid.
